led_pattern_game: RTL and testbench
===================================

Name: led_pattern_game

Overview:
Parametrised successor to the switch-compare running-light block. It compares a key field against a fixed target and drives an LED bank with one of four selectable patterns, paced by an internal clock divider. A debounced match freezes the bank in a "win" display. It sits between the board switch inputs and the LED outputs.

Parameters:
LED_W, 16, number of LEDs driven (≥2)
KEY_W, 4, width of compared key field
TARGET, 4'b1010, compare value (KEY_W bits)
DIV_MAX, 1_000_000, divider terminal count; tick period = DIV_MAX+1 clocks
MATCH_TICKS, 2, consecutive ticks key must equal TARGET before WIN (≥1)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous reset, active-low
key_i  in  KEY_W  key from switches
mode_i  in  2  pattern select: 0 FILL, 1 SHIFT, 2 BOUNCE, 3 BLINK
pause_i  in  1  high freezes divider and pattern
led_o  out  LED_W  registered LED drive
match_o  out  1  registered, high while in WIN
tick_o  out  1  one-cycle divider pulse (combinational from divider)

Behaviour:
- Reset (async, rstn low): led_o=0, match_o=0, state RUN, pos=0, dir=down, div_cnt=0, match_cnt=0, mode_q=0.
- Divider: width $clog2(DIV_MAX+1); increments each clk unless pause_i; wraps DIV_MAX→0. tick = (div_cnt==DIV_MAX) && !pause_i.
- Raw match: key_i==TARGET, combinational. Any cycle with raw match low clears match_cnt.
- mode_q registers mode_i each clk. If mode_i!=mode_q in RUN: next edge pos=0, dir=down, led_o=0; no pattern step that cycle, even on a tick.
- State RUN, on tick:
  - If raw match: if match_cnt==MATCH_TICKS-1 → WIN, led_o=1<<(LED_W-1), match_o=1, match_cnt=0; else match_cnt+1 and step pattern.
  - Else step pattern.
- Pattern step (pos in 0..LED_W):
  - FILL: pos<LED_W → set led_o[LED_W-1-pos], pos+1; pos==LED_W → led_o=0, pos=0. Cycle = LED_W+1 ticks.
  - SHIFT: led_o one-hot at bit LED_W-1-pos; pos wraps LED_W-1→0.
  - BOUNCE: one-hot as SHIFT; pos moves by dir, reverses at 0 and LED_W-1 without repeating an end (period 2*LED_W-2).
  - BLINK: led_o toggles between all-0 and all-1.
- State WIN: led_o held, match_o=1. Leaving WIN happens on the first tick with raw match low: → RUN, led_o=0, pos=0, dir=down, match_o=0. Raw-low cycles between ticks do not leave WIN.
- pause_i: no ticks, so pattern and WIN both hold. mode-change restart still applies.
- Simultaneous mode change and tick with raw match: the mode restart wins and match_cnt is not incremented.
- Reset mid-pattern or mid-WIN returns immediately to reset values.

Optional Feature:
LED_GAME_SPEED_EN
- Defined: adds input speed_i[1:0]. Effective terminal count = DIV_MAX>>speed_i, sampled when div_cnt wraps. If div_cnt already exceeds the new limit, it wraps on the next clk.
- Undefined: port absent; terminal count fixed at DIV_MAX.

Test Plan:
- DIV_MAX=3, LED_W=8, mode 0, key=0: release reset → tick_o every 4 clks; led_o 0x80,0xC0,…,0xFF, then 0x00 on the 9th tick, repeats.
- Mode 1 then mode 2 → SHIFT 0x80→0x01→0x80; BOUNCE 0x80…0x01,0x02…0x80; period 14 ticks.
- key=4'b1010, MATCH_TICKS=2 → match_o=1 and led_o=0x80 on the 2nd tick. Glitching key low for 1 clk between ticks before entry → entry delayed by the restart. Key low at a tick in WIN → led_o=0x00, match_o=0.
- Change mode mid-FILL at led_o=0xF0 → next clk led_o=0x00, pattern restarts from 0x80 on the next tick.
- pause_i high 20 clks mid-SHIFT → led_o and div_cnt unchanged; resumes the same sequence on release.
- Drop rstn asynchronously between clk edges in WIN → led_o=0 and match_o=0 immediately; with LED_GAME_SPEED_EN, speed_i=1 gives a tick period of 2 clks (DIV_MAX=3).

Source files
------------

// File: rtl/led_pattern_game.sv
// LED pattern game: compares key_i against TARGET and drives FILL/SHIFT/BOUNCE/BLINK patterns on a divider tick.
// Optional macro LED_GAME_SPEED_EN adds speed_i, which scales the divider terminal count down by 2**speed_i.
module led_pattern_game #(
    parameter int               LED_W       = 16,
    parameter int               KEY_W       = 4,
    parameter logic [KEY_W-1:0] TARGET      = 4'b1010,
    parameter int               DIV_MAX     = 1_000_000,
    parameter int               MATCH_TICKS = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [KEY_W-1:0] key_i,
    input  logic [1:0]       mode_i,
    input  logic             pause_i,
`ifdef LED_GAME_SPEED_EN
    input  logic [1:0]       speed_i,
`endif
    output logic [LED_W-1:0] led_o,
    output logic             match_o,
    output logic             tick_o
);
    localparam int DIV_W = $clog2(DIV_MAX + 1);
    localparam int POS_W = $clog2(LED_W + 1);
    localparam int MC_W  = $clog2(MATCH_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(DIV_MAX);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_W - 1);
    localparam logic [POS_W-1:0] POS_END  = POS_W'(LED_W);
    localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(MATCH_TICKS - 1);
    localparam logic [LED_W-1:0] LED_TOP  = {1'b1, {(LED_W-1){1'b0}}};

    typedef enum logic {S_RUN, S_WIN} state_t;
    typedef enum logic [1:0] {M_FILL, M_SHIFT, M_BOUNCE, M_BLINK} mode_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [POS_W-1:0] r_pos;
    logic             r_dir_up;
    logic [MC_W-1:0]  r_match_cnt;
    logic [1:0]       r_mode_q;
    logic [LED_W-1:0] r_led;
    logic             r_match;

    logic [DIV_W-1:0] w_div_lim;
    logic             w_wrap;
    logic             w_tick;
    logic             w_raw_match;
    logic             w_mode_chg;
    logic [LED_W-1:0] w_onehot;
    logic [LED_W-1:0] w_step_led;
    logic [POS_W-1:0] w_step_pos;
    logic             w_step_dir_up;

`ifdef LED_GAME_SPEED_EN
    assign w_div_lim = DIV_TC >> speed_i;
`else
    assign w_div_lim = DIV_TC;
`endif

    // Compare with >= so a count left above a freshly lowered limit wraps on the next clock.
    assign w_wrap      = (r_div_cnt >= w_div_lim);
    assign w_tick      = w_wrap && !pause_i;
    assign tick_o      = w_tick;
    assign w_raw_match = (key_i == TARGET);
    assign w_mode_chg  = (mode_i != r_mode_q);
    assign w_onehot    = LED_TOP >> r_pos;
    assign led_o       = r_led;
    assign match_o     = r_match;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div_cnt <= '0;
        end else if (!pause_i) begin
            // NOTE: sequential state always uses non-blocking assignment so every register samples pre-edge values.
            r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        w_step_led    = r_led;
        w_step_pos    = r_pos;
        w_step_dir_up = r_dir_up;
        case (mode_t'(r_mode_q))
            M_FILL: begin
                if (r_pos < POS_END) begin
                    w_step_led = r_led | w_onehot;
                    w_step_pos = r_pos + 1'b1;
                end else begin
                    w_step_led = '0;
                    w_step_pos = '0;
                end
            end
            M_SHIFT: begin
                w_step_led = w_onehot;
                w_step_pos = (r_pos >= POS_LAST) ? '0 : r_pos + 1'b1;
            end
            M_BOUNCE: begin
                w_step_led = w_onehot;
                if (!r_dir_up) begin
                    if (r_pos >= POS_LAST) begin
                        w_step_dir_up = 1'b1;
                        w_step_pos    = r_pos - 1'b1;
                    end else begin
                        w_step_pos = r_pos + 1'b1;
                    end
                end else if (r_pos == '0) begin
                    w_step_dir_up = 1'b0;
                    w_step_pos    = POS_W'(1);
                end else begin
                    w_step_pos = r_pos - 1'b1;
                end
            end
            default: begin
                w_step_led = (r_led == '0) ? '1 : '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_RUN;
            r_pos       <= '0;
            r_dir_up    <= 1'b0;
            r_match_cnt <= '0;
            r_mode_q    <= '0;
            r_led       <= '0;
            r_match     <= 1'b0;
        end else begin
            r_mode_q <= mode_i;
            // NOTE: a later non-blocking assignment to r_match_cnt below overrides this clear only when the key matches.
            if (!w_raw_match) begin
                r_match_cnt <= '0;
            end
            case (r_state)
                S_RUN: begin
                    if (w_mode_chg) begin
                        r_pos    <= '0;
                        r_dir_up <= 1'b0;
                        r_led    <= '0;
                    end else if (w_tick) begin
                        if (w_raw_match && (r_match_cnt == MC_LAST)) begin
                            r_state     <= S_WIN;
                            r_led       <= LED_TOP;
                            r_match     <= 1'b1;
                            r_match_cnt <= '0;
                        end else begin
                            if (w_raw_match) begin
                                r_match_cnt <= r_match_cnt + 1'b1;
                            end
                            r_led    <= w_step_led;
                            r_pos    <= w_step_pos;
                            r_dir_up <= w_step_dir_up;
                        end
                    end
                end
                default: begin
                    if (w_tick && !w_raw_match) begin
                        r_state  <= S_RUN;
                        r_led    <= '0;
                        r_pos    <= '0;
                        r_dir_up <= 1'b0;
                        r_match  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_led_pattern_game.sv
// Bench for led_pattern_game (LED_W=8, DIV_MAX=3): step-count reference model checked every cycle plus literal pins.
module tb_led_pattern_game;
    localparam int DIVM = 3;
    localparam int MT   = 2;
    localparam logic [3:0] TGT = 4'b1010;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic [3:0] key   = 4'd0;
    logic [1:0] mode  = 2'd0;
    logic       pause = 1'b0;
    logic [7:0] led;
    logic       match;
    logic       tick;
`ifdef LED_GAME_SPEED_EN
    logic [1:0] speed = 2'd0;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: divider phase, ticks stepped since the last restart, WIN flag.
    int       m_div    = 0;
    int       m_k      = 0;
    int       m_mcnt   = 0;
    bit       m_win    = 1'b0;
    logic [1:0] m_mode_q = 2'd0;
    bit       raw, tk, chg;

    led_pattern_game #(
        .LED_W(8), .KEY_W(4), .TARGET(TGT), .DIV_MAX(DIVM), .MATCH_TICKS(MT)
    ) dut (
        .clk(clk), .rstn(rstn), .key_i(key), .mode_i(mode), .pause_i(pause),
`ifdef LED_GAME_SPEED_EN
        .speed_i(speed),
`endif
        .led_o(led), .match_o(match), .tick_o(tick)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // LED value after k pattern steps in a given mode, straight from the pattern definitions.
    function automatic logic [7:0] exp_led(input logic [1:0] md, input int k, input bit win);
        int j, p, idx;
        logic [7:0] top;
        top = 8'h80;
        if (win) return top;
        if (k == 0) return 8'h00;
        case (md)
            2'd0: begin
                j = k % 9;
                return (j == 0) ? 8'h00 : 8'(((1 << j) - 1) << (8 - j));
            end
            2'd1: return top >> ((k - 1) % 8);
            2'd2: begin
                p   = (k - 1) % 14;
                idx = (p < 8) ? p : 14 - p;
                return top >> idx;
            end
            default: return (k % 2 == 1) ? 8'hFF : 8'h00;
        endcase
    endfunction

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            m_div = 0; m_k = 0; m_mcnt = 0; m_win = 1'b0; m_mode_q = 2'd0;
        end else begin
            raw = (key == TGT);
            tk  = (m_div == DIVM) && !pause;
            chg = (mode != m_mode_q);
            if (!pause) m_div = (m_div == DIVM) ? 0 : m_div + 1;
            if (!m_win) begin
                if (chg) m_k = 0;
                else if (tk) begin
                    if (raw && m_mcnt == MT - 1) begin
                        m_win = 1'b1; m_mcnt = 0;
                    end else begin
                        if (raw) m_mcnt++;
                        m_k++;
                    end
                end
            end else if (tk && !raw) begin
                m_win = 1'b0; m_k = 0;
            end
            if (!raw) m_mcnt = 0;
            m_mode_q = mode;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        check("model_led", led, exp_led(m_mode_q, m_k, m_win));
        check("model_match", match, m_win);
        check("model_tick", tick, (m_div == DIVM) && !pause);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        step(3);
        check("rst_led", led, 8'h00);
        check("rst_match", match, 1'b0);
        check("rst_tick", tick, 1'b0);
        rstn = 1'b1;

        // FILL
        step(3);  check("fill_tick_phase", tick, 1'b1);
        step(1);  check("fill_1", led, 8'h80); check("fill_tick_low", tick, 1'b0);
        step(4);  check("fill_2", led, 8'hC0);
        step(24); check("fill_full", led, 8'hFF);
        step(4);  check("fill_clear", led, 8'h00);
        step(4);  check("fill_again", led, 8'h80);
        step(12); check("fill_f0", led, 8'hF0);

        // mode change mid-FILL, then SHIFT
        mode = 2'd1;
        step(1);  check("restart_clear", led, 8'h00);
        step(3);  check("shift_1", led, 8'h80);
        step(28); check("shift_8", led, 8'h01);
        step(4);  check("shift_wrap", led, 8'h80);

        // BOUNCE
        mode = 2'd2;
        step(1);  check("bounce_clear", led, 8'h00);
        step(3);  check("bounce_1", led, 8'h80);
        step(28); check("bounce_end", led, 8'h01);
        step(4);  check("bounce_back", led, 8'h02);
        step(24); check("bounce_period", led, 8'h80);
        step(4);  check("bounce_next", led, 8'h40);

        // pause mid-SHIFT
        mode = 2'd1;
        step(4);  check("shift_re1", led, 8'h80);
        step(4);  check("shift_re2", led, 8'h40);
        step(1);
        pause = 1'b1;
        step(20); check("pause_hold", led, 8'h40); check("pause_tick", tick, 1'b0);
        pause = 1'b0;
        step(3);  check("pause_resume", led, 8'h20);

        // match entry, WIN hold, WIN exit
        key = TGT;
        step(4);  check("match_t1_led", led, 8'h10); check("match_t1", match, 1'b0);
        step(4);  check("win_led", led, 8'h80); check("win_match", match, 1'b1);
        step(1);
        key = 4'd0;
        step(1);
        key = TGT;
        step(2);  check("win_hold", match, 1'b1); check("win_hold_led", led, 8'h80);
        key = 4'd0;
        step(4);  check("win_exit_led", led, 8'h00); check("win_exit", match, 1'b0);

        // glitch between ticks delays entry
        key = TGT;
        step(4);  check("glitch_t1", led, 8'h80);
        step(1);
        key = 4'd0;
        step(1);
        key = TGT;
        step(2);  check("glitch_delay", match, 1'b0); check("glitch_led", led, 8'h40);
        step(4);  check("glitch_win", match, 1'b1);

        // asynchronous reset in WIN
        #2 rstn = 1'b0;
        #1 check("async_led", led, 8'h00); check("async_match", match, 1'b0);
        key = 4'd0;
        step(2);
        rstn = 1'b1;
        key  = TGT;

        // mode change coinciding with a matching tick keeps match_cnt
        step(4);  check("sim_t1", led, 8'h80); check("sim_t1_m", match, 1'b0);
        step(3);
        mode = 2'd3;
        step(1);  check("sim_restart", led, 8'h00); check("sim_nowin", match, 1'b0);
        step(4);  check("sim_win", match, 1'b1); check("sim_win_led", led, 8'h80);
        key = 4'd0;
        step(4);  check("sim_exit", led, 8'h00);
        step(4);  check("blink_on", led, 8'hFF);
        step(4);  check("blink_off", led, 8'h00);

        step(2);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
